// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 register-file peripheral: read/write access to NUM_REGS registers of
// DATA_W bits with burst auto-increment, read-back on cipo and per-register strobes.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, copi, ncs     raw SPI inputs (asynchronous to clk, synchronised here)
//   cipo, cipo_oe       read data and its pad enable (high only in a read data phase)
//   regs_flat           register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe           one-clk pulse on bit i when reg i is written
//   addr_err            one-clk pulse per word accessed at an address >= NUM_REGS
//   busy                synchronised chip-select activity
module spi_regfile_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         addr_err,
  output logic                         busy
);

  localparam int unsigned CMD_W  = ADDR_W + 1;
  localparam int unsigned MAX_B  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned CNT_W  = $clog2(MAX_B + 1);
  localparam int unsigned FLAT_W = NUM_REGS * DATA_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Input synchronisers, edge detection and post-reset re-arm tracking
  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync, vld_sync;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_prev, rise, fall, copi_bit, armed;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // vld_sync marks when ncs_s reflects a real post-reset sample, so a frame that
  // was cut by reset is not re-entered until ncs is genuinely seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      vld_sync  <= '0;
      sclk_prev <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      copi_bit  <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      rise      <= sclk_s & ~sclk_prev;
      fall      <= ~sclk_s & sclk_prev;
      copi_bit  <= copi_s;
      busy      <= ~ncs_s;
      if (vld_sync[SYNC_STAGES-1] && ncs_s) armed <= 1'b1;
    end
  end

  // Frame state and datapath
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d, cmd_word;
  logic [DATA_W-1:0]   shin_q, shin_d, shout_q, shout_d, word;
  logic [ADDR_W-1:0]   addr_q, addr_d, ld_addr;
  logic                rw_q, rw_d, ld_en, hit;
  logic [FLAT_W-1:0]   regs_d;
  logic                cipo_d, cipo_oe_d, addr_err_d;
  logic [NUM_REGS-1:0] wr_strobe_d;

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    regs_d      = regs_flat;
    cipo_d      = cipo;
    cipo_oe_d   = 1'b0;
    wr_strobe_d = '0;
    addr_err_d  = 1'b0;
    cmd_word    = CMD_W'({cmd_q, copi_bit});
    word        = DATA_W'({shin_q, copi_bit});
    ld_en       = 1'b0;
    ld_addr     = addr_q;
    hit         = 1'b0;

    if (state_q != IDLE && ncs_s) begin
      // Deselect abandons any partial word
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (armed && !ncs_s) state_d = CMD;
        end
        CMD: begin
          if (rise) begin
            cmd_d = cmd_word;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(CMD_W - 1)) begin
              rw_d    = cmd_word[CMD_W-1];
              addr_d  = cmd_word[ADDR_W-1:0];
              cnt_d   = '0;
              state_d = DATA;
              ld_en   = ~cmd_word[CMD_W-1];
              ld_addr = cmd_word[ADDR_W-1:0];
            end
          end
        end
        DATA: begin
          if (fall && !rw_q) begin
            cipo_d  = shout_q[DATA_W-1];
            shout_d = shout_q << 1;
          end
          if (rise) begin
            shin_d = word;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d  = '0;
              addr_d = addr_q + 1'b1;
              if (rw_q) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                    regs_d[i*DATA_W +: DATA_W] = word;
                    wr_strobe_d[i]             = 1'b1;
                    hit                        = 1'b1;
                  end
                end
                addr_err_d = ~hit;
              end else begin
                ld_en   = 1'b1;
                ld_addr = addr_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Shift-out reload; unimplemented addresses read as zero
    if (ld_en) begin
      shout_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (ld_addr == ADDR_W'(i)) begin
          shout_d = regs_flat[i*DATA_W +: DATA_W];
          hit     = 1'b1;
        end
      end
      addr_err_d = ~hit;
    end

    cipo_oe_d = (state_d == DATA) && !rw_d;
    if (!cipo_oe_d) cipo_d = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      shin_q    <= '0;
      shout_q   <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      regs_flat <= '0;
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      wr_strobe <= '0;
      addr_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      shin_q    <= shin_d;
      shout_q   <= shout_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      regs_flat <= regs_d;
      cipo      <= cipo_d;
      cipo_oe   <= cipo_oe_d;
      wr_strobe <= wr_strobe_d;
      addr_err  <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Bench for spi_regfile_ctrl: drives SPI frames, predicts strobe/error events and
// read-back words into queues, and compares them as the DUT produces them.
module tb_spi_regfile_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 5;
  localparam int unsigned AW = 7;
  localparam int unsigned SS = 2;
  localparam int HALF  = SS + 6;
  localparam int SETUP = SS + 6;
  localparam int GAP   = SS + 10;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs  = 1'b1;
  logic cipo, cipo_oe, addr_err, busy;
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0]    wr_strobe;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit          is_err;
    int          idx;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           ev_q[$];
  ev_t           ev;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] mdl [0:(1<<AW)-1];

  spi_regfile_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .addr_err  (addr_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  // Every strobe or error pulse must match the oldest predicted event
  always @(negedge clk) begin
    if (!rst && (wr_strobe != '0 || addr_err)) begin
      if (ev_q.size() == 0) begin
        chk("spurious_event", {wr_strobe, addr_err}, '0);
      end else begin
        ev = ev_q.pop_front();
        if (ev.is_err) begin
          chk("err_pulse", addr_err, 1);
          chk("err_strobe", wr_strobe, 0);
        end else begin
          chk("strobe", wr_strobe, NR'(1) << ev.idx);
          chk("wdata", regs_flat[ev.idx*DW +: DW], ev.data);
          chk("wr_err", addr_err, 0);
        end
      end
    end
  end

  task automatic plan_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    if (a < NR) begin
      mdl[a] = d;
      e = '{1'b0, int'(a), d};
    end else begin
      e = '{1'b1, 0, '0};
    end
    ev_q.push_back(e);
  endtask

  // n words read from a: the shift-out register loads a..a+n (one extra at the end)
  task automatic plan_read(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] aa;
    ev_t e;
    aa = a;
    for (int k = 0; k <= n; k++) begin
      if (k < n) rd_q.push_back((aa < NR) ? mdl[aa] : '0);
      if (aa >= NR) begin
        e = '{1'b1, 0, '0};
        ev_q.push_back(e);
      end
      aa = aa + 1'b1;
    end
  endtask

  task automatic sel();
    ncs = 1'b0;
    repeat (SETUP) @(negedge clk);
    chk("busy_sel", busy, 1);
  endtask

  task automatic desel();
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (GAP) @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  // Shift n bits MSB first; cipo/cipo_oe are sampled just before each rising edge
  task automatic send_bits(input logic [15:0] v, input int n, output logic [15:0] rv,
                           output int oe_cnt);
    logic [15:0] val;
    val    = v;
    rv     = '0;
    oe_cnt = 0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      repeat (HALF) @(negedge clk);
      rv = {rv[14:0], cipo};
      if (cipo_oe) oe_cnt++;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic wr_frame(input logic [AW-1:0] a);
    logic [15:0]   rv;
    int            oc;
    logic [AW-1:0] aa;
    logic [DW-1:0] d;
    aa = a;
    sel();
    send_bits({8'h00, 1'b1, a}, 1 + AW, rv, oc);
    while (tx_q.size() > 0) begin
      d = tx_q.pop_front();
      plan_write(aa, d);
      send_bits(16'(d), DW, rv, oc);
      chk("wr_cipo", rv, 0);
      chk("wr_oe", oc, 0);
      aa = aa + 1'b1;
    end
    desel();
    chk("regs", regs_flat, mdl_flat());
  endtask

  task automatic rd_frame(input logic [AW-1:0] a, input int n);
    logic [15:0]   rv;
    int            oc;
    logic [DW-1:0] exp;
    plan_read(a, n);
    sel();
    send_bits({8'h00, 1'b0, a}, 1 + AW, rv, oc);
    chk("rd_cmd_cipo", rv, 0);
    chk("rd_cmd_oe", oc, 0);
    for (int k = 0; k < n; k++) begin
      send_bits(16'h0000, DW, rv, oc);
      exp = (rd_q.size() > 0) ? rd_q.pop_front() : 'x;
      chk("rdata", rv[DW-1:0], exp);
      chk("rd_data_oe", oc, DW);
    end
    desel();
    chk("rd_idle_pins", {cipo_oe, cipo}, 0);
  endtask

  initial begin
    logic [15:0] rv;
    int          oc;
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;

    // Reset values
    repeat (4) @(negedge clk);
    chk("rst_regs", regs_flat, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {cipo_oe, cipo}, 0);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);

    // Single write, then a burst
    tx_q.push_back(8'hA5);
    wr_frame(7'h02);
    tx_q = '{8'h11, 8'h22, 8'h33};
    wr_frame(7'h00);

    // Read-back, plus a burst that runs past the last register
    tx_q.push_back(8'h5A);
    wr_frame(7'h03);
    rd_frame(7'h03, 1);
    rd_frame(7'h03, 2);

    // Out-of-range write and read, address wrap in both directions
    tx_q.push_back(8'hFF);
    wr_frame(7'h10);
    rd_frame(7'h7F, 2);
    tx_q = '{8'hAA, 8'hBB};
    wr_frame(7'h7F);

    // Short command: no effect
    sel();
    send_bits(16'h0015, 5, rv, oc);
    desel();
    chk("short_regs", regs_flat, mdl_flat());

    // Abort mid-word, then a full frame
    sel();
    send_bits({8'h00, 1'b1, 7'h01}, 1 + AW, rv, oc);
    send_bits(16'h000F, 4, rv, oc);
    desel();
    chk("abort_regs", regs_flat, mdl_flat());
    tx_q.push_back(8'h3C);
    wr_frame(7'h01);

    // Reset in the middle of a burst write
    sel();
    send_bits({8'h00, 1'b1, 7'h00}, 1 + AW, rv, oc);
    plan_write(7'h00, 8'h99);
    send_bits(16'h0099, DW, rv, oc);
    send_bits(16'h0004, 4, rv, oc);
    rst = 1'b1;
    #1;
    chk("mid_rst_regs", regs_flat, 0);
    chk("mid_rst_strobe", wr_strobe, 0);
    chk("mid_rst_err", addr_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pins", {cipo_oe, cipo}, 0);
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Still selected after release: these bits must be ignored
    send_bits({1'b1, 7'h01, 8'h77}, 1 + AW + DW, rv, oc);
    chk("post_rst_oe", oc, 0);
    desel();
    chk("post_rst_regs", regs_flat, 0);
    tx_q.push_back(8'hC3);
    wr_frame(7'h04);

    repeat (GAP) @(negedge clk);
    chk("ev_pending", ev_q.size(), 0);
    chk("rd_pending", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
